instr_loader: RTL and testbench

Upstream loader for the CPU's instruction memory. It takes the byte stream arriving on the chip's dedicated/bidirectional pins, packs every four bytes little-endian into a 32-bit instruction word, and issues single-cycle write strobes into the instruction RAM. It holds the CPU in reset-hold while a program is being loaded and releases it only after the last word has been committed, so the CPU never fetches a half-written program.

---
 rtl/instr_loader.sv | 191 +++++++++++++++++++
 tb/tb_instr_loader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// ---------------------------------------------------------------------------
// instr_loader
//
// Upstream loader for the CPU instruction memory. Packs the incoming byte
// stream little-endian into 32-bit words and issues one-cycle write strobes
// into the instruction RAM. Holds the CPU halted while a program is being
// loaded and releases it only once the last word has been committed.
//
// Parameters
//   ADDR_W      instruction-memory word address width (2^ADDR_W words)
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   load_mode   level: 1 = loading session active, 0 = run
//   byte_valid  byte_data is valid this cycle (honoured only while loading)
//   byte_data   program byte
//   mem_we      instruction-RAM write strobe, one cycle per word
//   mem_addr    word address for the write
//   mem_wdata   assembled instruction word
//   cpu_hold    1 = CPU must stay halted
//   word_count  words written in the current/last session (saturating)
//   overflow    sticky: a byte was dropped because memory was full
// ---------------------------------------------------------------------------
module instr_loader #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_mode,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic [ADDR_W:0]   word_count,
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH,
    RUN
  } state_t;

  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

  state_t            r_state;
  logic [1:0]        r_idx;
  logic [ADDR_W-1:0] r_wptr;
  logic [31:0]       r_asm;
  logic              r_memWe;
  logic [ADDR_W-1:0] r_memAddr;
  logic [31:0]       r_memWdata;
  logic              r_cpuHold;
  logic [ADDR_W:0]   r_wordCount;
  logic              r_overflow;

  state_t            w_nextState;
  logic [1:0]        w_nextIdx;
  logic [ADDR_W-1:0] w_nextWptr;
  logic [31:0]       w_nextAsm;
  logic              w_nextWe;
  logic [ADDR_W-1:0] w_nextAddr;
  logic [31:0]       w_nextWdata;
  logic              w_nextHold;
  logic [ADDR_W:0]   w_nextCount;
  logic              w_nextOvf;
  logic              w_startSession;
  logic              w_full;
  logic [31:0]       w_merged;

  assign w_full   = (r_wordCount == CAPACITY);
  // Lanes fill from the bottom, so OR-ing the byte into its lane position is
  // enough: the target lane is always still zero.
  assign w_merged = r_asm | ({24'b0, byte_data} << {r_idx, 3'b000});

  // State register and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_wptr      <= '0;
      r_asm       <= '0;
      r_memWe     <= 1'b0;
      r_memAddr   <= '0;
      r_memWdata  <= '0;
      r_cpuHold   <= 1'b1;
      r_wordCount <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_idx       <= w_nextIdx;
      r_wptr      <= w_nextWptr;
      r_asm       <= w_nextAsm;
      r_memWe     <= w_nextWe;
      r_memAddr   <= w_nextAddr;
      r_memWdata  <= w_nextWdata;
      r_cpuHold   <= w_nextHold;
      r_wordCount <= w_nextCount;
      r_overflow  <= w_nextOvf;
    end
  end

  // Next-state and next-output logic. Bytes arriving on the edge that enters
  // LOAD or leaves it are deliberately ignored.
  always_comb begin
    w_nextState    = r_state;
    w_nextIdx      = r_idx;
    w_nextWptr     = r_wptr;
    w_nextAsm      = r_asm;
    w_nextWe       = 1'b0;
    w_nextAddr     = r_memAddr;
    w_nextWdata    = r_memWdata;
    w_nextCount    = r_wordCount;
    w_nextOvf      = r_overflow;
    w_startSession = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (load_mode) begin
          w_nextState    = LOAD;
          w_startSession = 1'b1;
        end
      end
      LOAD: begin
        if (!load_mode) begin
          w_nextState = FLUSH;
          // A partially filled word is committed with zero upper lanes.
          if (r_idx != 2'd0 && !w_full) begin
            w_nextWe    = 1'b1;
            w_nextAddr  = r_wptr;
            w_nextWdata = r_asm;
            w_nextWptr  = r_wptr + ADDR_W'(1);
            w_nextCount = r_wordCount + (ADDR_W+1)'(1);
          end
          w_nextIdx = '0;
          w_nextAsm = '0;
        end else if (byte_valid) begin
          if (w_full) begin
            w_nextOvf = 1'b1;
          end else if (r_idx == 2'd3) begin
            w_nextWe    = 1'b1;
            w_nextAddr  = r_wptr;
            w_nextWdata = w_merged;
            w_nextWptr  = r_wptr + ADDR_W'(1);
            w_nextCount = r_wordCount + (ADDR_W+1)'(1);
            w_nextIdx   = '0;
            w_nextAsm   = '0;
          end else begin
            w_nextAsm = w_merged;
            w_nextIdx = r_idx + 2'd1;
          end
        end
      end
      FLUSH: begin
        w_nextState = RUN;
      end
      RUN: begin
        if (load_mode) begin
          w_nextState    = LOAD;
          w_startSession = 1'b1;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase

    // A new session always starts writing at address 0 with fresh counters.
    if (w_startSession) begin
      w_nextWptr  = '0;
      w_nextIdx   = '0;
      w_nextAsm   = '0;
      w_nextCount = '0;
      w_nextOvf   = 1'b0;
    end

    w_nextHold = (w_nextState != RUN);
  end

  assign mem_we     = r_memWe;
  assign mem_addr   = r_memAddr;
  assign mem_wdata  = r_memWdata;
  assign cpu_hold   = r_cpuHold;
  assign word_count = r_wordCount;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_instr_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_loader
//
// Self-checking bench for instr_loader with a small memory (ADDR_W=2) so the
// full/overflow behaviour is reached quickly. A session-level reference
// model keeps the accepted byte list and derives the expected writes from it.
// ---------------------------------------------------------------------------
module tb_instr_loader;

  localparam int AW  = 2;
  localparam int CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_mode;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_hold;
  logic [AW:0]   word_count;
  logic          overflow;

  always #5 clk = ~clk;

  instr_loader #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_mode  (load_mode),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .word_count (word_count),
    .overflow   (overflow)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model: session phase, accepted bytes, words written so far.
  int          mPhase;
  int          mBytes[$];
  int          mWords;
  bit          mOvf;
  bit          mWe;
  int          mAddr;
  logic [31:0] mData;
  bit          mHold;

  // Log of strobes actually seen on the RAM port.
  int          obsAddr[$];
  logic [31:0] obsData[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Little-endian word from the last n accepted bytes; missing lanes are 0.
  function automatic logic [31:0] packTail(int n);
    logic [31:0] w;
    int base;
    w    = '0;
    base = mBytes.size() - n;
    for (int k = 0; k < n; k++) w = w | (32'(mBytes[base+k]) << (8 * k));
    return w;
  endfunction

  task automatic modelReset();
    mPhase = 0;
    mBytes.delete();
    mWords = 0;
    mOvf   = 0;
    mWe    = 0;
    mAddr  = 0;
    mData  = '0;
    mHold  = 1;
  endtask

  task automatic modelStartSession();
    mBytes.delete();
    mWords = 0;
    mOvf   = 0;
  endtask

  // Phases: 0 idle, 1 loading, 2 flushing, 3 running.
  task automatic modelEdge(input logic lm, input logic bv, input logic [7:0] bd);
    int pending;
    mWe = 0;
    case (mPhase)
      0: if (lm) begin modelStartSession(); mPhase = 1; end
      1: begin
        if (!lm) begin
          pending = mBytes.size() % 4;
          if (pending != 0 && mWords < CAP) begin
            mWe   = 1;
            mAddr = mWords % CAP;
            mData = packTail(pending);
            mWords++;
          end
          mPhase = 2;
        end else if (bv) begin
          if (mWords == CAP) mOvf = 1;
          else begin
            mBytes.push_back(int'(bd));
            if (mBytes.size() % 4 == 0) begin
              mWe   = 1;
              mAddr = mWords % CAP;
              mData = packTail(4);
              mWords++;
            end
          end
        end
      end
      2: mPhase = 3;
      default: if (lm) begin modelStartSession(); mPhase = 1; end
    endcase
    mHold = (mPhase != 3);
  endtask

  task automatic compareAll();
    checkOutput("mem_we", 32'(mem_we), 32'(mWe));
    if (mem_we) begin
      obsAddr.push_back(int'(mem_addr));
      obsData.push_back(mem_wdata);
    end
    if (mWe) begin
      checkOutput("mem_addr", 32'(mem_addr), 32'(mAddr));
      checkOutput("mem_wdata", mem_wdata, mData);
    end
    checkOutput("cpu_hold", 32'(cpu_hold), 32'(mHold));
    checkOutput("word_count", 32'(word_count), 32'(mWords));
    checkOutput("overflow", 32'(overflow), 32'(mOvf));
  endtask

  // One clock: drive at the falling edge, model at the rising edge, check at
  // the next falling edge.
  task automatic applyStimulus(input logic lm, input logic bv, input logic [7:0] bd);
    load_mode  = lm;
    byte_valid = bv;
    byte_data  = bd;
    @(posedge clk);
    modelEdge(lm, bv, bd);
    @(negedge clk);
    compareAll();
  endtask

  task automatic sendBytes(input int n, input int first);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, 8'(first + i));
  endtask

  function automatic int logAddr(int i);
    return (i < obsAddr.size()) ? obsAddr[i] : -1;
  endfunction

  function automatic logic [31:0] logData(int i);
    return (i < obsData.size()) ? obsData[i] : 32'hxxxxxxxx;
  endfunction

  // Reset raised mid-cycle; outputs must clear without any clock edge.
  task automatic asyncReset();
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_word_count", 32'(word_count), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    modelReset();
    @(negedge clk);
    rst        = 1'b0;
    load_mode  = 1'b0;
    byte_valid = 1'b0;
  endtask

  logic [7:0] gapBytes[4];

  initial begin
    rst        = 1'b1;
    load_mode  = 1'b0;
    byte_valid = 1'b0;
    byte_data  = '0;
    modelReset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("reset_mem_wdata", mem_wdata, 32'd0);
    checkOutput("reset_cpu_hold", 32'(cpu_hold), 32'd1);
    applyStimulus(1'b0, 1'b1, 8'h55);

    // Streaming load of two full words.
    obsAddr.delete(); obsData.delete();
    applyStimulus(1'b1, 1'b1, 8'hEE);
    applyStimulus(1'b1, 1'b1, 8'h13);
    applyStimulus(1'b1, 1'b1, 8'h00);
    applyStimulus(1'b1, 1'b1, 8'h00);
    applyStimulus(1'b1, 1'b1, 8'h00);
    applyStimulus(1'b1, 1'b1, 8'h93);
    applyStimulus(1'b1, 1'b1, 8'h00);
    applyStimulus(1'b1, 1'b1, 8'h10);
    applyStimulus(1'b1, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h77);
    checkOutput("stream_hold_e0", 32'(cpu_hold), 32'd1);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("stream_hold_e1", 32'(cpu_hold), 32'd0);
    checkOutput("stream_writes", 32'(obsAddr.size()), 32'd2);
    checkOutput("stream_addr0", 32'(logAddr(0)), 32'd0);
    checkOutput("stream_data0", logData(0), 32'h00000013);
    checkOutput("stream_addr1", 32'(logAddr(1)), 32'd1);
    checkOutput("stream_data1", logData(1), 32'h00100093);
    checkOutput("stream_count", 32'(word_count), 32'd2);

    // Partial flush of a six-byte program.
    obsAddr.delete(); obsData.delete();
    applyStimulus(1'b1, 1'b0, 8'h00);
    sendBytes(6, 1);
    applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("partial_writes", 32'(obsAddr.size()), 32'd2);
    checkOutput("partial_addr1", 32'(logAddr(1)), 32'd1);
    checkOutput("partial_data1", logData(1), 32'h00000605);
    checkOutput("partial_count", 32'(word_count), 32'd2);

    // Gapped bytes: idle cycles between valid bytes must not advance a lane.
    obsAddr.delete(); obsData.delete();
    gapBytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    applyStimulus(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) applyStimulus(1'b1, 1'b0, 8'($urandom));
      applyStimulus(1'b1, 1'b1, gapBytes[i]);
    end
    applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("gap_writes", 32'(obsAddr.size()), 32'd1);
    checkOutput("gap_data", logData(0), 32'hDDCCBBAA);

    // Overflow: 20 bytes into a four-word memory.
    obsAddr.delete(); obsData.delete();
    applyStimulus(1'b1, 1'b0, 8'h00);
    sendBytes(20, 8'h40);
    checkOutput("ovf_flag", 32'(overflow), 32'd1);
    applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("ovf_writes", 32'(obsAddr.size()), 32'd4);
    for (int i = 0; i < 4; i++) checkOutput("ovf_addr", 32'(logAddr(i)), 32'(i));
    checkOutput("ovf_data3", logData(3), 32'h4F4E4D4C);
    checkOutput("ovf_count", 32'(word_count), 32'd4);

    // Reload from RUN: fresh session at address 0.
    obsAddr.delete(); obsData.delete();
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("reload_hold", 32'(cpu_hold), 32'd1);
    checkOutput("reload_ovf", 32'(overflow), 32'd0);
    checkOutput("reload_count0", 32'(word_count), 32'd0);
    sendBytes(4, 8'h21);
    checkOutput("reload_addr", 32'(logAddr(0)), 32'd0);
    checkOutput("reload_data", logData(0), 32'h24232221);
    checkOutput("reload_count1", 32'(word_count), 32'd1);

    // Asynchronous reset in an overflowed session.
    sendBytes(13, 8'h60);
    asyncReset();

    // Randomised sessions against the model.
    for (int s = 0; s < 60; s++) begin
      repeat ($urandom_range(1, 30))
        applyStimulus(1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
      repeat ($urandom_range(1, 4))
        applyStimulus(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
      if ($urandom_range(0, 9) == 0) asyncReset();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
